imm_gen_pipe: RTL and testbench

- Pipelined, parametrised RV immediate generator placed between instruction fetch and decode/register-read.
- Accepts one instruction per cycle over a valid/ready handshake and produces the XLEN sign-/zero-extended immediate, a format code, an illegal-opcode flag and a pass-through tag.
- Adds the following over the combinational generator:
  - XLEN 32/64 support, including RV64 OP-IMM-32/OP-32.
  - SYSTEM/CSR immediates and FENCE.
  - Illegal detection.
  - A 2-entry skid buffer giving a fully registered, backpressure-safe interface.

---
 rtl/imm_gen_pipe_if.sv | 25 ++
 rtl/imm_gen_pipe.sv | 124 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Fetch-to-decode handshake bundle for the immediate generator: instruction in, decoded immediate out.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instr_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  imm_o;
    logic [2:0]       fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  in_valid_i, instr_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );
    modport master (
        output in_valid_i, instr_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV immediate generator behind a 2-entry skid buffer; every output comes straight from a flop.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    imm_gen_pipe_if.slave bus
);
    localparam bit RV64 = (XLEN == 64);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
        FMT_U = 3'd4, FMT_J = 3'd5, FMT_CSRZ = 3'd6, FMT_CSRA = 3'd7
    } fmt_e;

    typedef struct packed {
        logic             vld;
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t m_q, m_d, k_q, k_d, dec;
    logic [31:0] w;
    logic        acc, pop;
    logic        unused_f3;

    assign w         = bus.instr_i;
    assign unused_f3 = ^w[13:12];

    always_comb begin
        dec     = '0;
        dec.vld = 1'b1;
        dec.tag = bus.tag_i;
        dec.fmt = FMT_NONE;
        if (w[1:0] != 2'b11) begin
            dec.ill = 1'b1;
        end else begin
            unique case (w[6:0])
                7'b0110011: ;
                7'b0111011: dec.ill = !RV64;
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'($signed(w[31:20]));
                end
                7'b0011011: begin
                    if (RV64) begin
                        dec.fmt = FMT_I;
                        dec.imm = XLEN'($signed(w[31:20]));
                    end else begin
                        dec.ill = 1'b1;
                    end
                end
                7'b0100011: begin
                    dec.fmt = FMT_S;
                    dec.imm = XLEN'($signed({w[31:25], w[11:7]}));
                end
                7'b1100011: begin
                    dec.fmt = FMT_B;
                    dec.imm = XLEN'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                end
                7'b0110111, 7'b0010111: begin
                    dec.fmt = FMT_U;
                    dec.imm = XLEN'($signed({w[31:12], 12'b0}));
                end
                7'b1101111: begin
                    dec.fmt = FMT_J;
                    dec.imm = XLEN'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                end
                7'b1110011: begin
                    // funct3[2] separates the CSR*I forms (uimm in rs1) from register CSR ops / ECALL.
                    if (w[14]) begin
                        dec.fmt = FMT_CSRZ;
                        dec.imm = XLEN'(w[19:15]);
                    end else begin
                        dec.fmt = FMT_CSRA;
                        dec.imm = XLEN'(w[31:20]);
                    end
                end
                default: dec.ill = 1'b1;
            endcase
        end
    end

    assign bus.in_ready_o = !k_q.vld;
    assign acc            = bus.in_valid_i && !k_q.vld;
    assign pop            = m_q.vld && bus.out_ready_i;

    always_comb begin
        m_d = m_q;
        k_d = k_q;
        if (pop) begin
            if (k_q.vld) begin
                m_d     = k_q;
                k_d.vld = 1'b0;
            end else if (!acc) begin
                m_d.vld = 1'b0;
            end
        end
        // K is only ever written when M is stalled, so ordering is M then K.
        if (acc) begin
            if (!m_q.vld || bus.out_ready_i) m_d = dec;
            else                             k_d = dec;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q <= '0;
            k_q <= '0;
        end else begin
            m_q <= m_d;
            k_q <= k_d;
        end
    end

    assign bus.out_valid_o = m_q.vld;
    assign bus.imm_o       = m_q.imm;
    assign bus.fmt_o       = m_q.fmt;
    assign bus.illegal_o   = m_q.ill;
    assign bus.tag_o       = m_q.tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an RV32 and an RV64 instance with identical traffic and checks both against a queue-based model.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    assign b64.in_valid_i  = b32.in_valid_i;
    assign b64.instr_i     = b32.instr_i;
    assign b64.tag_i       = b32.tag_i;
    assign b64.out_ready_i = b32.out_ready_i;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (.clk_i(clk), .rst_ni(rst_n), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (.clk_i(clk), .rst_ni(rst_n), .bus(b64));

    typedef struct {
        logic [31:0] w;
        logic [31:0] t;
    } txn_t;

    txn_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_acc = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA field layouts, always computed at 64 bits.
    function automatic void ref_dec(input logic [31:0] w, input bit r64,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        logic [63:0] sx;
        imm = 64'd0; fmt = 3'd0; ill = 1'b0;
        sx  = {{32{w[31]}}, w};
        if (w[1:0] != 2'b11) ill = 1'b1;
        else case (w[6:0])
            7'h33: ;
            7'h3B: ill = !r64;
            7'h13, 7'h03, 7'h67, 7'h0F: begin fmt = 1; imm = $signed(sx) >>> 20; end
            7'h1B: if (r64) begin fmt = 1; imm = $signed(sx) >>> 20; end else ill = 1'b1;
            7'h23: begin fmt = 2; imm = {sx[63:12] >> 7, 7'd0} | {59'd0, w[11:7]}; imm = {{52{w[31]}}, w[31:25], w[11:7]}; end
            7'h63: begin fmt = 3; imm = {{52{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; end
            7'h37, 7'h17: begin fmt = 4; imm = sx & ~64'hFFF; end
            7'h6F: begin fmt = 5; imm = {{44{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; end
            7'h73: if (w[14]) begin fmt = 6; imm = (w >> 15) & 32'h1F; end
                   else begin fmt = 7; imm = w >> 20; end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic check_state();
        logic [63:0] imm; logic [2:0] fmt; logic ill;
        chk("vld32", b32.out_valid_o, q.size() > 0);
        chk("vld64", b64.out_valid_o, q.size() > 0);
        chk("rdy32", b32.in_ready_o, q.size() < 2);
        chk("rdy64", b64.in_ready_o, q.size() < 2);
        if (q.size() > 0) begin
            ref_dec(q[0].w, 1'b0, imm, fmt, ill);
            chk("imm32", {32'd0, b32.imm_o}, {32'd0, imm[31:0]});
            chk("fmt32", b32.fmt_o, fmt);
            chk("ill32", b32.illegal_o, ill);
            chk("tag32", b32.tag_o, q[0].t);
            ref_dec(q[0].w, 1'b1, imm, fmt, ill);
            chk("imm64", b64.imm_o, imm);
            chk("fmt64", b64.fmt_o, fmt);
            chk("ill64", b64.illegal_o, ill);
            chk("tag64", b64.tag_o, q[0].t);
        end
    endtask

    // One clock: present inputs, advance the model across the edge, check just after it.
    task automatic cyc(input bit v, input logic [31:0] w, input logic [31:0] t, input bit rdy);
        bit acc, pop;
        b32.in_valid_i  = v;
        b32.instr_i     = w;
        b32.tag_i       = t;
        b32.out_ready_i = rdy;
        acc = v && (q.size() < 2);
        pop = rdy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back('{w: w, t: t});
            n_acc++;
        end
        check_state();
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_vld"}, b32.out_valid_o | b64.out_valid_o, 0);
        chk({nm, "_rdy"}, b32.in_ready_o & b64.in_ready_o, 1);
        chk({nm, "_imm"}, {32'd0, b32.imm_o} | b64.imm_o, 0);
        chk({nm, "_fmt"}, b32.fmt_o | b64.fmt_o, 0);
        chk({nm, "_ill"}, b32.illegal_o | b64.illegal_o, 0);
        chk({nm, "_tag"}, b32.tag_o | b64.tag_o, 0);
    endtask

    logic [31:0] strm_w [4] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h0010006F};
    logic [31:0] strm_i [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800};
    logic [2:0]  strm_f [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    logic [6:0]  ops   [15] = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h1B, 7'h23,
                                7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F, 7'h2B};

    initial begin
        b32.in_valid_i = 0; b32.instr_i = 0; b32.tag_i = 0; b32.out_ready_i = 0;
        #1;
        chk_reset_outs("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming, back-to-back
        for (int i = 0; i < 4; i++) begin
            cyc(1, strm_w[i], 32'h100 + i, 1);
            chk("strm_imm", {32'd0, b32.imm_o}, {32'd0, strm_i[i]});
            chk("strm_fmt", b32.fmt_o, strm_f[i]);
            chk("strm_vld", b32.out_valid_o, 1);
        end
        cyc(0, 0, 0, 1);

        cyc(1, 32'h12345037, 1, 1);
        chk("u32_imm", {32'd0, b32.imm_o}, 64'h12345000);
        chk("u32_fmt", b32.fmt_o, 4);
        cyc(1, 32'h80000037, 2, 1);
        chk("u64_imm", b64.imm_o, 64'hFFFFFFFF80000000);
        cyc(1, 32'h3002D073, 3, 1);
        chk("csrz_imm", b64.imm_o, 5);
        chk("csrz_fmt", b32.fmt_o, 6);
        cyc(1, 32'h30002073, 4, 1);
        chk("csra_imm", {32'd0, b32.imm_o}, 64'h300);
        chk("csra_fmt", b64.fmt_o, 7);
        cyc(1, 32'h0000001B, 5, 1);
        chk("w32_ill", b32.illegal_o, 1);
        chk("w32_imm", {32'd0, b32.imm_o}, 0);
        chk("w64_fmt", b64.fmt_o, 1);
        chk("w64_ill", b64.illegal_o, 0);
        cyc(1, 32'hFFF00090, 6, 1);
        chk("lowbits_ill", b32.illegal_o & b64.illegal_o, 1);
        cyc(0, 0, 0, 1);

        // Backpressure: A, B accepted, C stalled
        cyc(1, 32'h00100093, 32'hA, 0);
        chk("bp_rdyA", b32.in_ready_o, 1);
        cyc(1, 32'h00200093, 32'hB, 0);
        chk("bp_rdyB", b32.in_ready_o, 0);
        chk("bp_tagB", b32.tag_o, 32'hA);
        cyc(1, 32'h00300093, 32'hC, 0);
        chk("bp_hold", b32.tag_o, 32'hA);
        chk("bp_holdimm", {32'd0, b32.imm_o}, 1);
        cyc(1, 32'h00300093, 32'hC, 1);
        chk("bp_out1", b32.tag_o, 32'hB);
        cyc(1, 32'h00300093, 32'hC, 1);
        chk("bp_out2", b32.tag_o, 32'hC);
        cyc(0, 0, 0, 1);
        chk("bp_drain", b32.out_valid_o, 0);

        // Async reset with both entries full
        cyc(1, 32'h00100093, 32'h11, 0);
        cyc(1, 32'h00200093, 32'h22, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 32'h00500093, 32'h33, 1);
        cyc(1, 32'h00700093, 32'h44, 1);
        chk("rst_first", b32.tag_o, 32'h44);
        cyc(0, 0, 0, 1);

        // Random traffic
        n_acc = 0;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 14)];
            if ($urandom_range(0, 19) == 0) w[1:0] = 2'($urandom_range(0, 2));
            cyc($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 9) < 7);
        end
        chk("rand_count", n_acc, 10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
